// File: rtl/zest_p2_spi_master.sv
// Zest P2 shared serial-bus initiator: one register transaction at a time to the
// LMK01801 (uWire), the two AD9653 ADCs (3-wire SPI) or the AD9781 DAC (4-wire SPI).
module zest_p2_spi_master #(
    parameter int unsigned SCLK_HALF = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  target,
    input  logic        rnw,
    input  logic [12:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        sclk,
    output logic        sdio_out,
    output logic        sdio_oe,
    input  logic        sdio_in,
    input  logic        u4_sdo,
    output logic        adc_dir,
    output logic        u1_le,
    output logic        u2_csb,
    output logic        u3_csb,
    output logic        u4_csb
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_LATCH, S_GAP
    } state_e;

    localparam logic [8:0] HALF_LAST = 9'(SCLK_HALF - 1);
    localparam logic [8:0] LE_LAST   = 9'(2 * SCLK_HALF - 1);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [4:0]  last_q, last_d;
    logic        phase_q, phase_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  rd_q, rd_d;
    logic [1:0]  tgt_q, tgt_d;
    logic        rnw_q, rnw_d;
    logic        turn_q, turn_d;

    logic        busy_q, busy_d, done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sclk_q, sclk_d, sdio_out_q, sdio_out_d;
    logic        sdio_oe_q, sdio_oe_d, u1_le_q, u1_le_d;
    logic        u2_csb_q, u2_csb_d, u3_csb_q, u3_csb_d, u4_csb_q, u4_csb_d;
    logic        half_wrap, sel_active;

    always_comb begin
        // NOTE: every _d defaults to its _q first so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        last_d  = last_q;
        phase_d = phase_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        tgt_d   = tgt_q;
        rnw_d   = rnw_q;
        turn_d  = turn_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        half_wrap = (cnt_q == HALF_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    rnw_d   = rnw && (target != 2'd0);
                    turn_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_SETUP;
                    // Frames are left-aligned so sh_q[31] is always the bit on the wire.
                    case (target)
                        2'd0: begin
                            sh_d   = wdata;
                            last_d = 5'd31;
                        end
                        2'd3: begin
                            sh_d   = {rnw, 2'b00, addr[4:0], rnw ? 8'h00 : wdata[7:0], 16'h0000};
                            last_d = 5'd15;
                        end
                        default: begin
                            sh_d   = {rnw, 2'b00, addr, rnw ? 8'h00 : wdata[7:0], 8'h00};
                            last_d = 5'd23;
                        end
                    endcase
                end
            end
            S_SETUP: begin
                cnt_d = cnt_q + 9'd1;
                if (half_wrap) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + 9'd1;
                if (half_wrap) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        rd_d    = {rd_q[6:0], (tgt_q == 2'd3) ? u4_sdo : sdio_in};
                    end else begin
                        phase_d = 1'b0;
                        sh_d    = {sh_q[30:0], 1'b0};
                        if (bit_q == last_q) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                        // ADC reads release SDIO at the falling edge that opens bit 16.
                        if (rnw_q && (tgt_q != 2'd3) && (bit_q == 5'd15)) begin
                            turn_d = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + 9'd1;
                if (half_wrap) begin
                    cnt_d   = '0;
                    state_d = (tgt_q == 2'd0) ? S_LATCH : S_GAP;
                end
            end
            S_LATCH: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == LE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 9'd1;
                if (half_wrap) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (rnw_q) begin
                        rdata_d = rd_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin values are decoded from next state so every output leaves a flop.
        sel_active = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        busy_d     = (state_d != S_IDLE);
        sclk_d     = (state_d == S_SHIFT) && phase_d;
        sdio_out_d = ((state_d == S_SETUP) || (state_d == S_SHIFT)) && sh_d[31];
        sdio_oe_d  = sel_active && !turn_d;
        u1_le_d    = (state_d == S_LATCH);
        u2_csb_d   = !(sel_active && (tgt_d == 2'd1));
        u3_csb_d   = !(sel_active && (tgt_d == 2'd2));
        u4_csb_d   = !(sel_active && (tgt_d == 2'd3));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            last_q     <= '0;
            phase_q    <= 1'b0;
            sh_q       <= '0;
            rd_q       <= '0;
            tgt_q      <= '0;
            rnw_q      <= 1'b0;
            turn_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            sclk_q     <= 1'b0;
            sdio_out_q <= 1'b0;
            sdio_oe_q  <= 1'b0;
            u1_le_q    <= 1'b0;
            u2_csb_q   <= 1'b1;
            u3_csb_q   <= 1'b1;
            u4_csb_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            phase_q    <= phase_d;
            sh_q       <= sh_d;
            rd_q       <= rd_d;
            tgt_q      <= tgt_d;
            rnw_q      <= rnw_d;
            turn_q     <= turn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            sclk_q     <= sclk_d;
            sdio_out_q <= sdio_out_d;
            sdio_oe_q  <= sdio_oe_d;
            u1_le_q    <= u1_le_d;
            u2_csb_q   <= u2_csb_d;
            u3_csb_q   <= u3_csb_d;
            u4_csb_q   <= u4_csb_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign sclk     = sclk_q;
    assign sdio_out = sdio_out_q;
    assign sdio_oe  = sdio_oe_q;
    assign adc_dir  = sdio_oe_q;
    assign u1_le    = u1_le_q;
    assign u2_csb   = u2_csb_q;
    assign u3_csb   = u3_csb_q;
    assign u4_csb   = u4_csb_q;

endmodule

// File: tb/tb_zest_p2_spi_master.sv
// Directed bench for zest_p2_spi_master: records each frame at the pins and
// compares it with hand-derived frames, timings and read data (SCLK_HALF = 4).
module tb_zest_p2_spi_master;

    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  target = '0;
    logic        rnw = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        sdio_in = 1'b0;
    logic        u4_sdo = 1'b0;
    logic        busy, done, sclk, sdio_out, sdio_oe, adc_dir, u1_le;
    logic        u2_csb, u3_csb, u4_csb;
    logic [7:0]  rdata;

    zest_p2_spi_master #(.SCLK_HALF(H)) dut (
        .clk(clk), .rst(rst), .start(start), .target(target), .rnw(rnw),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .sclk(sclk), .sdio_out(sdio_out), .sdio_oe(sdio_oe), .sdio_in(sdio_in),
        .u4_sdo(u4_sdo), .adc_dir(adc_dir), .u1_le(u1_le),
        .u2_csb(u2_csb), .u3_csb(u3_csb), .u4_csb(u4_csb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-transaction observations.
    int          busy_cyc, u2_low, u3_low, u4_low, le_cyc, le_first, edges;
    int          multi_low = 0;
    logic [63:0] cap, oe_mask, dir_mask;
    logic        first_busy, timed_out;

    task automatic launch(input logic [1:0] t, input logic r, input logic [12:0] a,
                          input logic [31:0] w);
        target = t;
        rnw    = r;
        addr   = a;
        wdata  = w;
        start  = 1'b1;
    endtask

    task automatic check_reset_pins(input string tag);
        check(tag, {busy, done, sclk, sdio_out, sdio_oe, adc_dir, u1_le, u2_csb, u3_csb, u4_csb},
              10'b00_0000_0111);
    endtask

    // Runs one launched transaction to its done cycle (or to a reset at abort_edge).
    task automatic run(input logic [7:0] resp, input bit dac_model, input bit glitch,
                       input int abort_edge);
        logic prev_sclk;
        bit   finished;
        int   idx;
        busy_cyc = 0; u2_low = 0; u3_low = 0; u4_low = 0;
        le_cyc = 0; le_first = 0; edges = 0;
        cap = '0; oe_mask = '0; dir_mask = '0;
        prev_sclk = 1'b0;
        finished  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        first_busy = busy;
        for (int c = 0; c < 2000 && !finished; c++) begin
            if (c > 0) @(negedge clk);
            if (done) begin
                finished = 1'b1;
            end else begin
                if (busy) busy_cyc++;
                if (!u2_csb) u2_low++;
                if (!u3_csb) u3_low++;
                if (!u4_csb) u4_low++;
                if ((int'(!u2_csb) + int'(!u3_csb) + int'(!u4_csb)) > 1) multi_low++;
                if (u1_le) begin
                    le_cyc++;
                    if (le_first == 0) le_first = busy_cyc;
                end
                if (sclk && !prev_sclk) begin
                    cap      = {cap[62:0], sdio_out};
                    oe_mask  = {oe_mask[62:0], sdio_oe};
                    dir_mask = {dir_mask[62:0], adc_dir};
                    edges++;
                end
                prev_sclk = sclk;
                // Peripheral model: ADC answers on SDIO for bits 16..23, DAC on SDO for bits 8..15.
                sdio_in = 1'b0;
                u4_sdo  = 1'b0;
                if (!dac_model && edges >= 16 && edges < 24 && !sdio_oe) begin
                    idx = 23 - edges;
                    sdio_in = resp[idx[2:0]];
                end
                if (dac_model && edges >= 8 && edges < 16) begin
                    idx = 15 - edges;
                    u4_sdo = resp[idx[2:0]];
                end
                if (glitch && c == 20) begin
                    launch(2'd3, 1'b1, 13'h1FFF, 32'hFFFF_FFFF);
                end else if (glitch && c == 21) begin
                    start = 1'b0;
                end
                if (abort_edge >= 0 && edges == abort_edge && !sclk) begin
                    rst = 1'b1;
                    #1;
                    check_reset_pins("reset_mid_shift_pins");
                    check("reset_mid_shift_rdata", rdata, 8'h00);
                    @(negedge clk);
                    rst = 1'b0;
                    finished = 1'b1;
                end
            end
        end
        sdio_in = 1'b0;
        u4_sdo  = 1'b0;
        timed_out = !finished;
        check("timeout", timed_out, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_pins("reset_pins");
        check("reset_rdata", rdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // 1: ADC write to U2.
        launch(2'd1, 1'b0, 13'h014, 32'h0000_00A5);
        run(8'h00, 1'b0, 1'b0, -1);
        check("t1_first_busy", first_busy, 1'b1);
        check("t1_busy_cycles", busy_cyc, 204);
        check("t1_u2_low", u2_low, 200);
        check("t1_u3_u4_low", u3_low + u4_low, 0);
        check("t1_edges", edges, 24);
        check("t1_frame", cap[23:0], 24'h0014A5);
        check("t1_oe", oe_mask[23:0], 24'hFFFFFF);
        check("t1_busy_done", {busy, done}, 2'b01);
        check("t1_rdata", rdata, 8'h00);
        @(negedge clk);
        check("t1_done_width", done, 1'b0);

        // 2: ADC read from U3 with turnaround.
        launch(2'd2, 1'b1, 13'h001, 32'h0);
        run(8'h87, 1'b0, 1'b0, -1);
        check("t2_instr", cap[23:8], 16'h8001);
        check("t2_oe", oe_mask[23:0], 24'hFFFF00);
        check("t2_dir", dir_mask[23:0], 24'hFFFF00);
        check("t2_u3_low", u3_low, 200);
        check("t2_u2_low", u2_low, 0);
        check("t2_busy_cycles", busy_cyc, 204);
        check("t2_rdata", rdata, 8'h87);

        // 3: DAC read from U4.
        launch(2'd3, 1'b1, 13'h01F, 32'h0);
        run(8'h3C, 1'b1, 1'b0, -1);
        check("t3_edges", edges, 16);
        check("t3_frame", cap[15:0], 16'h9F00);
        check("t3_oe", oe_mask[15:0], 16'hFFFF);
        check("t3_u4_low", u4_low, 136);
        check("t3_busy_cycles", busy_cyc, 140);
        check("t3_rdata", rdata, 8'h3C);

        // 4: LMK uWire write.
        launch(2'd0, 1'b0, 13'h0, 32'hDEAD_BEEF);
        run(8'h00, 1'b0, 1'b0, -1);
        check("t4_edges", edges, 32);
        check("t4_frame", cap[31:0], 32'hDEAD_BEEF);
        check("t4_csb_low", u2_low + u3_low + u4_low, 0);
        check("t4_le_cycles", le_cyc, 8);
        check("t4_le_first", le_first, 265);
        check("t4_busy_cycles", busy_cyc, 276);
        check("t4_rdata_hold", rdata, 8'h3C);

        // 5: start while busy is ignored; start in the done cycle is accepted.
        launch(2'd1, 1'b0, 13'h014, 32'h0000_003C);
        run(8'h00, 1'b0, 1'b1, -1);
        check("t5_frame", cap[23:0], 24'h00143C);
        check("t5_u4_low", u4_low, 0);
        check("t5_busy_cycles", busy_cyc, 204);
        launch(2'd3, 1'b0, 13'h005, 32'h0000_005A);
        run(8'h00, 1'b1, 1'b0, -1);
        check("t5_chain_first_busy", first_busy, 1'b1);
        check("t5_chain_frame", cap[15:0], 16'h055A);
        check("t5_chain_busy_cycles", busy_cyc, 140);

        // 6: reset during an ADC read, then a clean write.
        launch(2'd1, 1'b1, 13'h001, 32'h0);
        run(8'h87, 1'b0, 1'b0, 10);
        @(negedge clk);
        launch(2'd2, 1'b0, 13'h123, 32'h0000_0042);
        run(8'h00, 1'b0, 1'b0, -1);
        check("t6_frame", cap[23:0], 24'h012342);
        check("t6_busy_cycles", busy_cyc, 204);
        check("t6_u3_low", u3_low, 200);
        check("t6_rdata", rdata, 8'h00);

        check("one_csb_low", multi_low, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
